uart_rx_capture: RTL and testbench



---
 rtl/uart_rx_capture.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO, with sticky error flags.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
`ifdef UART_RX_PARITY_EN
  , parameter bit        PARITY_ODD   = 1'b0
`endif
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             rx,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd3;
`endif
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [2:0]       state;
  logic             rx_m, rx_s, rx_p;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [PTR_W-1:0] wptr, rptr;
  logic [7:0]       mem [FIFO_DEPTH];

  logic tick_half, tick_full;
  logic push, fe_set, do_pop, do_push, ovr_set;

  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);
  assign push      = (state == STOP) && tick_full && rx_s;
  assign fe_set    = (state == STOP) && tick_full && !rx_s;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = CNT_W'(wptr - rptr);
  assign busy    = (state != IDLE);
  assign rd_data = empty ? 8'h00 : mem[rptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands when rd_en is high.
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr_set = push && full && !do_pop;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_p      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_p      <= rx_s;
      frame_err <= fe_set  | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun & ~err_clr);
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);

      case (state)
        IDLE: begin
          if (rx_p && !rx_s) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (tick_full) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;
  assign par_set = (state == PARITY) && tick_full && ((^shreg ^ rx_s) != PARITY_ODD);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) parity_err <= 1'b0;
    else          parity_err <= par_set | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: table of single frames plus hand-written
// false-start, overrun, mid-frame reset and (when enabled) parity sequences.
module tb_uart_rx_capture;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          rx;
  logic          rd_en;
  logic          err_clr;
  logic [7:0]    rd_data;
  logic          empty, full, busy, frame_err, overrun, parity_err;
  logic [CW-1:0] count;

  int tests  = 0;
  int failed = 0;

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic [7:0] exp_head;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge HCLK);
  endtask

  // Drives bits[0..n-1] LSB first, one bit time each, then idles the line high.
  task automatic send_raw(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      rx = bits[i];
      cycles(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_raw({2'b00, stop, d, 1'b0}, 10);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, {24'h0, rd_data}, {24'h0, exp});
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h41, 1'b1, 1'b0, 8'h41, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h33, 1'b1, 1'b0, 8'h33, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0};

    HRESETn = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    cycles(3);
    check("rst_empty", {31'h0, empty}, 32'd1);
    check("rst_full", {31'h0, full}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_flags", {29'h0, frame_err, overrun, parity_err}, 32'd0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    HRESETn = 1'b1;
    cycles(4);

    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        rx = 1'b0;
        cycles(40);
        rx = 1'b1;
      end
      cycles(20);
      check($sformatf("v%0d_empty", v), {31'h0, empty}, {31'h0, vecs[v].exp_empty});
      check($sformatf("v%0d_count", v), 32'(count), vecs[v].exp_empty ? 32'd0 : 32'd1);
      check($sformatf("v%0d_head", v), {24'h0, rd_data}, {24'h0, vecs[v].exp_head});
      check($sformatf("v%0d_ferr", v), {31'h0, frame_err}, {31'h0, vecs[v].exp_ferr});
      check($sformatf("v%0d_busy", v), {31'h0, busy}, 32'd0);
      if (!vecs[v].exp_empty) begin
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
        check($sformatf("v%0d_popped", v), {31'h0, empty}, 32'd1);
      end
      pulse_clr();
      check($sformatf("v%0d_ferr_clr", v), {31'h0, frame_err}, 32'd0);
    end

    // False start: 4 low cycles must be rejected within CPB/2+3 cycles of the fall.
    begin
      int unsigned n = 0;
      logic seen_busy = 1'b0;
      rx = 1'b0;
      for (int unsigned i = 0; i < 30; i++) begin
        if (i == 4) rx = 1'b1;
        cycles(1);
        n++;
        if (busy) seen_busy = 1'b1;
        if (seen_busy && !busy) break;
      end
      check("fs_went_busy", {31'h0, seen_busy}, 32'd1);
      check("fs_idle_in_time", {31'h0, (n <= CPB / 2 + 3) && !busy}, 32'd1);
      cycles(CPB);
      check("fs_count", 32'(count), 32'd0);
    end

    // Overrun: 17 frames into a 16-entry FIFO with no reads.
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
    cycles(4);
    check("ovr_full", {31'h0, full}, 32'd1);
    check("ovr_count", 32'(count), 32'd16);
    check("ovr_flag", {31'h0, overrun}, 32'd1);
    for (int i = 0; i < 16; i++) pop_expect($sformatf("ovr_rd%0d", i), 8'(i));
    check("ovr_drained", {31'h0, empty}, 32'd1);
    pulse_clr();
    check("ovr_clr", {31'h0, overrun}, 32'd0);

    // Mid-frame reset: start bit plus 4 data bits of 0xA5, then reset.
    send_raw({6'h00, 4'h5, 1'b0}, 5);
    HRESETn = 1'b0;
    cycles(2);
    HRESETn = 1'b1;
    cycles(2 * CPB);
    check("mrst_busy", {31'h0, busy}, 32'd0);
    check("mrst_count0", 32'(count), 32'd0);
    send_byte(8'h5A, 1'b1);
    cycles(4);
    check("mrst_count1", 32'(count), 32'd1);
    pop_expect("mrst_head", 8'h5A);
    check("mrst_empty", {31'h0, empty}, 32'd1);

`ifdef UART_RX_PARITY_EN
    send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    cycles(4);
    check("par_ok_err", {31'h0, parity_err}, 32'd0);
    pop_expect("par_ok_head", 8'h07);
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    cycles(4);
    check("par_bad_err", {31'h0, parity_err}, 32'd1);
    check("par_bad_count", 32'(count), 32'd1);
    pop_expect("par_bad_head", 8'h07);
    pulse_clr();
    check("par_clr", {31'h0, parity_err}, 32'd0);
`else
    check("par_tied", {31'h0, parity_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
